noc_output_tx: RTL and testbench

- Avalon-MM slave that transmits words from the Nios processor onto the NoC output link.
- Software writes a destination address and data words. Words are buffered in a small FIFO and presented on a valid/ready streaming interface.
- The NoC side sees one registered output stage. Each word carries the destination that was current when the word was written.

---
 rtl/noc_output_tx.sv | 169 ++++++++++++++++
 tb/tb_noc_output_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_tx.sv
// Avalon-MM slave that queues Nios-written words and streams them onto the NoC output link.
// Optional NOC_OUTPUT_TX_IRQ_EN adds an irq output and a CONTROL irq_mask bit.
module noc_output_tx #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEST_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] noc_out_data,
  output logic [DEST_W-1:0] noc_out_dest,
  output logic              noc_out_valid,
  input  logic              noc_out_ready
`ifdef NOC_OUTPUT_TX_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [LVL_W-1:0]   count_q;
  logic [DEST_W-1:0]  dest_q;
  logic               enable_q;
  logic               drop_q;
`ifdef NOC_OUTPUT_TX_IRQ_EN
  logic               irq_mask_q;
`endif

  logic        wr_c;
  logic        wr_data_c;
  logic        wr_dest_c;
  logic        wr_ctrl_c;
  logic        flush_c;
  logic        full_c;
  logic        fifo_empty_c;
  logic        push_c;
  logic        drop_set_c;
  logic        load_c;
  logic [31:0] status_c;
  logic [31:0] ctrl_rd_c;
  logic [31:0] rd_next_c;

  // Bus decode and FIFO/output-stage handshake terms
  always_comb begin
    wr_c         = chipselect & ~write_n;
    wr_data_c    = wr_c & (address == 2'd0);
    wr_dest_c    = wr_c & (address == 2'd1);
    wr_ctrl_c    = wr_c & (address == 2'd3);
    flush_c      = wr_ctrl_c & writedata[2];
    full_c       = (count_q == DEPTH_LVL);
    fifo_empty_c = (count_q == '0);
    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot
    push_c       = wr_data_c & ~full_c & ~flush_c;
    drop_set_c   = wr_data_c & full_c & ~flush_c;
    load_c       = (~noc_out_valid | noc_out_ready) & ~fifo_empty_c & enable_q;
  end

  // Register read mux
  always_comb begin
    status_c            = '0;
    status_c[0]         = fifo_empty_c & ~noc_out_valid;
    status_c[1]         = full_c;
    status_c[2]         = drop_q;
    status_c[8 +: LVL_W] = count_q;
    status_c[16]        = noc_out_valid;

    ctrl_rd_c           = '0;
    ctrl_rd_c[0]        = enable_q;
`ifdef NOC_OUTPUT_TX_IRQ_EN
    ctrl_rd_c[3]        = irq_mask_q;
`endif

    rd_next_c = '0;
    case (address)
      2'd0:    rd_next_c = '0;
      2'd1:    rd_next_c = 32'(dest_q);
      2'd2:    rd_next_c = status_c;
      default: rd_next_c = ctrl_rd_c;
    endcase
  end

  // FIFO storage; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr_q] <= '{dest: dest_q, data: writedata[DATA_W-1:0]};
    end
  end

  // FIFO pointers and fill level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_c) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (load_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_c, load_c})
        2'b10:   count_q <= count_q + LVL_W'(1);
        2'b01:   count_q <= count_q - LVL_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Control/status registers and registered read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dest_q     <= '0;
      enable_q   <= 1'b0;
      drop_q     <= 1'b0;
      readdata   <= '0;
`ifdef NOC_OUTPUT_TX_IRQ_EN
      irq_mask_q <= 1'b0;
      irq        <= 1'b0;
`endif
    end else begin
      readdata <= rd_next_c;
      if (wr_dest_c) dest_q <= writedata[DEST_W-1:0];
      if (wr_ctrl_c) begin
        enable_q   <= writedata[0];
`ifdef NOC_OUTPUT_TX_IRQ_EN
        irq_mask_q <= writedata[3];
`endif
      end
      if (wr_ctrl_c & writedata[1]) drop_q <= 1'b0;
      else if (drop_set_c)          drop_q <= 1'b1;
`ifdef NOC_OUTPUT_TX_IRQ_EN
      irq <= irq_mask_q & status_c[0];
`endif
    end
  end

  // Output register stage toward the NoC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      noc_out_data  <= '0;
      noc_out_dest  <= '0;
      noc_out_valid <= 1'b0;
    end else if (load_c) begin
      noc_out_data  <= mem[rd_ptr_q].data;
      noc_out_dest  <= mem[rd_ptr_q].dest;
      noc_out_valid <= 1'b1;
    end else if (noc_out_valid & noc_out_ready) begin
      noc_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_noc_output_tx.sv
// Self-checking bench for noc_output_tx: directed test-plan steps plus random traffic
// against a queue-based reference model.
module tb_noc_output_tx;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned DEST_W     = 8;
  localparam int unsigned FIFO_DEPTH = 8;

  logic              clk;
  logic              reset;
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] noc_out_data;
  logic [DEST_W-1:0] noc_out_dest;
  logic              noc_out_valid;
  logic              noc_out_ready;
`ifdef NOC_OUTPUT_TX_IRQ_EN
  logic              irq;
`endif

  noc_output_tx #(.DATA_W(DATA_W), .DEST_W(DEST_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .noc_out_data(noc_out_data), .noc_out_dest(noc_out_dest),
    .noc_out_valid(noc_out_valid), .noc_out_ready(noc_out_ready)
`ifdef NOC_OUTPUT_TX_IRQ_EN
    , .irq(irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DEST_W+DATA_W-1:0] q[$];
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [DEST_W-1:0] m_dest;
  logic [DEST_W-1:0] m_destreg;
  logic              m_en;
  logic              m_drop;
  logic              m_mask;
  logic [31:0]       m_rd;
  logic              m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 0; m_data = '0; m_dest = '0; m_destreg = '0;
    m_en = 0; m_drop = 0; m_mask = 0; m_rd = '0; m_irq = 0;
  endtask

  function automatic logic model_empty();
    return (q.size() == 0) && !m_valid;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] r;
    case (a)
      2'd0: r = 32'h0;
      2'd1: r = 32'(m_destreg);
      2'd2: r = (32'(m_valid) << 16) | (32'(q.size()) << 8) | (32'(m_drop) << 2)
              | (32'(q.size() == FIFO_DEPTH) << 1) | 32'(model_empty());
`ifdef NOC_OUTPUT_TX_IRQ_EN
      default: r = (32'(m_mask) << 3) | 32'(m_en);
`else
      default: r = 32'(m_en);
`endif
    endcase
    return r;
  endfunction

  // Advance the model by one clock using the currently driven inputs
  task automatic model_step();
    logic wr, full, load, flush, drop_set, irq_n;
    logic [31:0] rd_n;
    logic [DEST_W+DATA_W-1:0] e;
    wr       = chipselect & ~write_n;
    rd_n     = model_read(address);
    irq_n    = m_mask & model_empty();
    full     = (q.size() == FIFO_DEPTH);
    load     = (!m_valid || noc_out_ready) && (q.size() != 0) && m_en;
    flush    = wr && (address == 2'd3) && writedata[2];
    drop_set = 0;
    if (load) begin
      e = q.pop_front();
      m_valid = 1; m_data = e[DATA_W-1:0]; m_dest = e[DATA_W +: DEST_W];
    end else if (m_valid && noc_out_ready) begin
      m_valid = 0;
    end
    if (wr && address == 2'd0 && !flush) begin
      if (!full) q.push_back({m_destreg, writedata[DATA_W-1:0]});
      else drop_set = 1;
    end
    if (flush) q.delete();
    if (wr && address == 2'd3 && writedata[1]) m_drop = 0;
    else if (drop_set) m_drop = 1;
    if (wr && address == 2'd3) begin
      m_en = writedata[0];
`ifdef NOC_OUTPUT_TX_IRQ_EN
      m_mask = writedata[3];
`endif
    end
    if (wr && address == 2'd1) m_destreg = writedata[DEST_W-1:0];
    m_rd  = rd_n;
    m_irq = irq_n;
  endtask

  // One clock: update model, take the edge, then compare all outputs
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("valid", 32'(noc_out_valid), 32'(m_valid));
    chk("data", 32'(noc_out_data), 32'(m_data));
    chk("dest", 32'(noc_out_dest), 32'(m_dest));
    chk("readdata", readdata, m_rd);
`ifdef NOC_OUTPUT_TX_IRQ_EN
    chk("irq", 32'(irq), 32'(m_irq));
`endif
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    cyc();
    chipselect = 0; write_n = 1;
  endtask

  task automatic idle(input logic [1:0] a, input int n);
    chipselect = 0; write_n = 1; address = a;
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    reset = 1; address = 0; chipselect = 0; write_n = 1; writedata = '0; noc_out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Reset state and STATUS read
    idle(2'd2, 1);
    chk("rst_status", readdata, 32'h1);
    chk("rst_valid", 32'(noc_out_valid), 32'h0);

    // Single word with one-cycle latency
    noc_out_ready = 1;
    wr_reg(2'd3, 32'h1);
    wr_reg(2'd1, 32'h2A);
    wr_reg(2'd0, 32'h11111111);
    chk("lat_not_yet", 32'(noc_out_valid), 32'h0);
    idle(2'd2, 1);
    chk("single_valid", 32'(noc_out_valid), 32'h1);
    chk("single_data", noc_out_data, 32'h11111111);
    chk("single_dest", 32'(noc_out_dest), 32'h2A);
    idle(2'd2, 2);
    chk("single_done", 32'(noc_out_valid), 32'h0);
    chk("single_empty", readdata, 32'h1);

    // Overflow, drop clear, then burst drain
    noc_out_ready = 0;
    wr_reg(2'd3, 32'h0);
    for (int i = 0; i < 9; i++) wr_reg(2'd0, 32'hA0000000 + 32'(i));
    idle(2'd2, 1);
    chk("full_status", readdata, 32'h806);
    wr_reg(2'd3, 32'h2);
    idle(2'd2, 1);
    chk("drop_cleared", readdata, 32'h802);
    noc_out_ready = 1;
    wr_reg(2'd3, 32'h1);
    for (int i = 0; i < 8; i++) begin
      idle(2'd2, 1);
      chk("burst_valid", 32'(noc_out_valid), 32'h1);
      chk("burst_data", noc_out_data, 32'hA0000000 + 32'(i));
    end
    idle(2'd2, 1);
    chk("burst_end", 32'(noc_out_valid), 32'h0);

    // Backpressure hold and enable clear
    noc_out_ready = 0;
    wr_reg(2'd0, 32'h44444444);
    idle(2'd2, 1);
    chk("bp_valid", 32'(noc_out_valid), 32'h1);
    wr_reg(2'd0, 32'h55555555);
    idle(2'd2, 5);
    wr_reg(2'd3, 32'h0);
    chk("bp_hold_valid", 32'(noc_out_valid), 32'h1);
    chk("bp_hold_data", noc_out_data, 32'h44444444);
    chk("bp_hold_dest", 32'(noc_out_dest), 32'h2A);
    noc_out_ready = 1;
    idle(2'd2, 1);
    chk("bp_xfer", 32'(noc_out_valid), 32'h0);
    idle(2'd2, 3);
    chk("bp_blocked", 32'(noc_out_valid), 32'h0);
    wr_reg(2'd3, 32'h1);
    idle(2'd2, 1);
    chk("bp_resume_data", noc_out_data, 32'h55555555);
    idle(2'd2, 2);

    // Destination captured per word
    wr_reg(2'd1, 32'h01);
    wr_reg(2'd0, 32'h00000101);
    wr_reg(2'd1, 32'h02);
    chk("dest1", 32'(noc_out_dest), 32'h01);
    chk("dest1_data", noc_out_data, 32'h00000101);
    wr_reg(2'd0, 32'h00000202);
    idle(2'd1, 1);
    chk("dest2", 32'(noc_out_dest), 32'h02);
    chk("dest_read", readdata, 32'h02);
    idle(2'd2, 2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      chipselect    = 1'($urandom_range(0, 1));
      write_n       = 1'($urandom_range(0, 1));
      address       = 2'($urandom);
      writedata     = $urandom;
      noc_out_ready = ($urandom_range(0, 3) != 0);
      if (address == 2'd3) begin
        writedata[0] = ($urandom_range(0, 4) != 0);
        writedata[2] = ($urandom_range(0, 7) == 0);
      end
      cyc();
    end
    idle(2'd2, 1);

    // Asynchronous reset during a burst
    noc_out_ready = 0;
    wr_reg(2'd3, 32'h1);
    wr_reg(2'd0, 32'hDEADBEEF);
    wr_reg(2'd0, 32'hCAFEF00D);
    chk("pre_rst_valid", 32'(noc_out_valid), 32'h1);
    #3 reset = 1;
    #1;
    chk("async_rst_valid", 32'(noc_out_valid), 32'h0);
    chk("async_rst_data", noc_out_data, 32'h0);
    model_reset();
    @(posedge clk);
    #1 reset = 0;
    idle(2'd2, 1);
    chk("post_rst_status", readdata, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
